// File: rtl/uart_pkg.sv
// Shared definitions for the result UART transmitter.
//   - ASCII constants used when building the report message
//   - Byte-serialiser FSM state type
//   - Default bit period (100 MHz clock, 115200 baud)
//   - Helpers that map a nibble to an uppercase hex digit and pick message bytes
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Message is four hex digits followed by CR LF.
  localparam logic [2:0] LAST_BYTE = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StStartBit,
    StDataBits,
    StStopBit
  } uart_state_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = ASCII_0 + {4'h0, nib};
    end else begin
      ch = ASCII_A + {4'h0, nib - 4'd10};
    end
    return ch;
  endfunction

  // Byte idx of the report for result word d (idx 6/7 never occur).
  function automatic logic [7:0] msg_byte(input logic [15:0] d, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = hex_ascii(d[15:12]);
      3'd1:    b = hex_ascii(d[11:8]);
      3'd2:    b = hex_ascii(d[7:4]);
      3'd3:    b = hex_ascii(d[3:0]);
      3'd4:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser.
// Sends one frame (start 0, eight data bits LSB first, stop 1), each bit held
// CLKS_PER_BIT cycles. A new byte may be loaded while idle or during the final
// stop-bit cycle, which lets the parent chain frames with no idle gap.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   load       in   take byte_in and start a frame (honoured when idle or last_cycle)
//   byte_in    in   byte to send
//   last_cycle out  high during the final cycle of the stop bit
//   txd        out  registered serial line, idles high
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       last_cycle,
  output logic       txd
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            txd_q, txd_d;

  logic            bit_end;
  logic [2:0]      bit_nxt;

  assign bit_end    = (cnt_q == CntLast);
  assign bit_nxt    = bit_q + 3'd1;
  assign last_cycle = (state_q == StStopBit) && bit_end;
  assign txd        = txd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;

    // Baud counter free-runs inside a frame and wraps at each bit boundary.
    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end

    case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StStartBit;
          shreg_d = byte_in;
          cnt_d   = '0;
          txd_d   = 1'b0;
        end
      end
      StStartBit: begin
        if (bit_end) begin
          state_d = StDataBits;
          bit_d   = 3'd0;
          txd_d   = shreg_q[0];
        end
      end
      StDataBits: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStopBit;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_nxt;
            txd_d = shreg_q[bit_nxt];
          end
        end
      end
      StStopBit: begin
        if (bit_end) begin
          bit_d = 3'd0;
          if (load) begin
            // Back-to-back frame: next start bit begins on the following cycle.
            state_d = StStartBit;
            shreg_d = byte_in;
            txd_d   = 1'b0;
          end else begin
            state_d = StIdle;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Serial reporter for the calculator result.
// On an accepted start the 16-bit result is latched and sent as four uppercase
// hex digits followed by CR LF, 8N1, frames back to back.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-low reset
//   start     in   single-cycle request, sampled only while busy is low
//   data      in   result word, captured when start is accepted
//   busy      out  high while the 6-byte message is in flight
//   done      out  one-cycle pulse after the last stop bit
//   UART_TXD  out  serial line, idles high
module result_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data,
  output logic        busy,
  output logic        done,
  output logic        UART_TXD
);

  logic [15:0] data_q, data_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        last_cycle;
  logic        more_bytes;
  logic        msg_end;
  logic        load;
  logic [7:0]  byte_in;

  assign accept     = start && !busy_q;
  assign more_bytes = last_cycle && (byte_idx_q != LAST_BYTE);
  assign msg_end    = last_cycle && (byte_idx_q == LAST_BYTE);
  assign load       = accept || more_bytes;

  // The first digit comes straight from the input so the start bit can go out
  // the cycle after acceptance; later bytes come from the holding register.
  assign byte_in = accept ? hex_ascii(data[15:12]) : msg_byte(data_q, byte_idx_q + 3'd1);

  always_comb begin
    data_d     = data_q;
    byte_idx_d = byte_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (accept) begin
      data_d     = data;
      byte_idx_d = 3'd0;
      busy_d     = 1'b1;
    end else if (more_bytes) begin
      byte_idx_d = byte_idx_q + 3'd1;
    end else if (msg_end) begin
      byte_idx_d = 3'd0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q     <= 16'h0000;
      byte_idx_q <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      data_q     <= data_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .byte_in    (byte_in),
    .last_cycle (last_cycle),
    .txd        (UART_TXD)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx with CLKS_PER_BIT=4.
// A waveform model turns each accepted request into the expected per-cycle
// line/busy/done sequence; a compare process checks every cycle against it.
// Directed scenarios also decode bytes at bit centres and check literal values.
module tb_result_uart_tx;

  localparam int unsigned Cpb = 4;
  localparam int unsigned MsgCycles = 60 * Cpb;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data;
  logic        busy;
  logic        done;
  logic        uart_txd;

  int checks;
  int errors;

  result_uart_tx #(
    .CLKS_PER_BIT (Cpb)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .UART_TXD (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic txd;
    logic busy;
    logic done;
  } exp_t;

  localparam exp_t IdleExp = '{txd: 1'b1, busy: 1'b0, done: 1'b0};

  exp_t exp_q[$];
  exp_t cur;

  logic [7:0] rx_bytes [6];

  function automatic logic [7:0] model_byte(input logic [15:0] d, input int k);
    string hexdig = "0123456789ABCDEF";
    int    nib;
    if (k == 4) return 8'h0D;
    if (k == 5) return 8'h0A;
    nib = int'((d >> (12 - 4 * k)) & 16'h000F);
    return 8'(hexdig[nib]);
  endfunction

  // Full expected waveform for one message, one entry per cycle, then the done cycle.
  task automatic build_msg(input logic [15:0] d);
    logic [7:0] b;
    logic [9:0] frame;
    for (int k = 0; k < 6; k++) begin
      b = model_byte(d, k);
      frame = {1'b1, b, 1'b0};
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < int'(Cpb); c++) begin
          exp_q.push_back('{txd: frame[j], busy: 1'b1, done: 1'b0});
        end
      end
    end
    exp_q.push_back('{txd: 1'b1, busy: 1'b0, done: 1'b1});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic pulse_start(input logic [15:0] d);
    start = 1'b1;
    data  = d;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Call in the cycle right after acceptance (before its falling edge).
  // Samples each bit centre of the six frames, then checks the done cycle.
  task automatic rx_msg(input string name, input logic [47:0] want);
    int busy_hi;
    int slot;
    int k;
    int j;
    logic [7:0] w;
    busy_hi = 0;
    for (int cyc = 1; cyc <= int'(MsgCycles); cyc++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_hi++;
      if (((cyc - 1) % int'(Cpb)) == 2) begin
        slot = (cyc - 1) / int'(Cpb);
        k = slot / 10;
        j = slot % 10;
        if (j == 0) chk({name, "_startbit"}, 32'(uart_txd), 32'd0);
        else if (j == 9) chk({name, "_stopbit"}, 32'(uart_txd), 32'd1);
        else rx_bytes[k][j-1] = uart_txd;
      end
    end
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd1);
    chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({name, "_txd_in_done"}, 32'(uart_txd), 32'd1);
    chk({name, "_busy_cycles"}, 32'(busy_hi), 32'(MsgCycles));
    for (int b = 0; b < 6; b++) begin
      w = want[47 - 8 * b -: 8];
      chk($sformatf("%s_byte%0d", name, b), 32'(rx_bytes[b]), 32'(w));
    end
  endtask

  task automatic count_low(input string name, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk(name, 32'(lows), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    start  = 1'b0;
    data   = 16'h0000;
    cur    = IdleExp;

    fork
      // Waveform model: accepted request replaces the pending schedule.
      forever begin
        @(posedge clk);
        if (!rst) begin
          exp_q.delete();
          cur = IdleExp;
        end else begin
          if (start && !cur.busy) begin
            exp_q.delete();
            build_msg(data);
          end
          cur = (exp_q.size() > 0) ? exp_q.pop_front() : IdleExp;
        end
      end
      // Per-cycle compare.
      forever begin
        @(negedge clk);
        checks++;
        if (uart_txd !== cur.txd || busy !== cur.busy || done !== cur.done) begin
          errors++;
          $display("FAIL cycle_cmp at %0t: txd/busy/done=%b%b%b expected %b%b%b",
                   $time, uart_txd, busy, done, cur.txd, cur.busy, cur.done);
        end
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", 32'(uart_txd), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Result 0x0009.
    pulse_start(16'h0009);
    rx_msg("r0009", {8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A});
    repeat (5) @(posedge clk);
    #1;

    // All letters, with data changed one cycle after acceptance.
    pulse_start(16'hABCD);
    data = 16'h5555;
    rx_msg("rABCD", {8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A});
    repeat (5) @(posedge clk);
    #1;

    // Start while busy is ignored.
    pulse_start(16'h1234);
    fork
      rx_msg("r1234", {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A});
      begin
        repeat (50) @(posedge clk);
        #1;
        pulse_start(16'hFFFF);
      end
    join
    count_low("no_second_msg", 300);

    // Start in the done cycle.
    @(posedge clk);
    #1;
    pulse_start(16'h0F0F);
    rx_msg("r0F0F", {8'h30, 8'h46, 8'h30, 8'h46, 8'h0D, 8'h0A});
    start = 1'b1;
    data  = 16'h00FF;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_cycle_start_bit", 32'(uart_txd), 32'd0);
    chk("done_cycle_busy", 32'(busy), 32'd1);
    rx_msg("r00FF", {8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A});
    repeat (5) @(posedge clk);
    #1;

    // Reset during DATA_BITS of byte 2 (cycles 85..116 of the message).
    pulse_start(16'h1234);
    repeat (95) @(posedge clk);
    #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_txd", 32'(uart_txd), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    rst = 1'b1;
    count_low("line_high_after_reset", 200);

    // Block still works after a mid-frame reset.
    @(posedge clk);
    #1;
    pulse_start(16'hC0DE);
    rx_msg("rC0DE", {8'h43, 8'h30, 8'h44, 8'h45, 8'h0D, 8'h0A});
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Serial reporter for the calculator datapath. It takes the 16-bit result that the mode/operation FSM produces in its output state and transmits it on `UART_TXD` as four uppercase ASCII hex digits followed by CR LF, using 8N1 framing. It sits directly downstream of the calculator FSM, alongside the `leds` output, and drives the board's UART TX pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal values are ≥ 2.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-low reset. It is sampled on the rising edge of `clk`, and `rst`=0 resets the block.
- `start`  in  1: single-cycle request from the calculator FSM. It is sampled only while `busy`=0.
- `data`  in  16: result word. It is captured on the cycle `start` is accepted.
- `busy`  out  1: high while a 6-byte message is in flight.
- `done`  out  1: one-cycle pulse when the last stop bit completes.
- `UART_TXD`  out  1: serial line. It idles high.

## Operation
- Reset values:
  - `UART_TXD`=1, `busy`=0, `done`=0.
  - Internal state: FSM=IDLE, byte index=0, bit index=0, baud counter=0.
- Accepting a request:
  - `start`=1 while `busy`=0 latches `data` into a 16-bit holding register and begins a message.
  - `start` while `busy`=1 is ignored. The holding register is not disturbed.
- Message content, in order (byte index 0..5):
  - Byte 0: hex(`data[15:12]`)
  - Byte 1: hex(`data[11:8]`)
  - Byte 2: hex(`data[7:4]`)
  - Byte 3: hex(`data[3:0]`)
  - Byte 4: 0x0D
  - Byte 5: 0x0A
- Hex mapping:
  - Nibble 0–9 maps to 0x30+n.
  - Nibble 10–15 maps to 0x41+(n−10). Letters are uppercase only.
- Frame per byte:
  - Start bit 0.
  - 8 data bits, LSB first.
  - Stop bit 1.
  - Each bit is held exactly `CLKS_PER_BIT` cycles.
- FSM states:
  - IDLE → START_BIT on an accepted `start`.
  - START_BIT → DATA_BITS after `CLKS_PER_BIT` cycles.
  - DATA_BITS → STOP_BIT after 8 bits.
  - STOP_BIT → START_BIT (next byte) at the end of the stop bit if byte index < 5.
  - STOP_BIT → IDLE at the end of the stop bit if byte index = 5. This transition asserts `done`.
- Width rules:
  - Baud counter width is $clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`−1, then wraps to 0.
  - Bit index is 3 bits. Byte index is 3 bits, range 0..5; values 6 and 7 are unreachable.
- Reset mid-frame: all state returns to reset values on the next edge, and `UART_TXD` goes high immediately. No partial frame is completed.

## Timing
- Start latency:
  - `start` is accepted at edge N.
  - `busy`=1 and `UART_TXD`=0 (start bit) from cycle N+1.
- Frame spacing: frames are back-to-back with no idle gap. The start bit of byte k+1 begins the cycle after the last stop-bit cycle of byte k.
- Message length: a message occupies exactly 60·`CLKS_PER_BIT` cycles, from cycle N+1 to cycle N+60·`CLKS_PER_BIT`.
- Completion:
  - `done`=1 and `busy`=0 in cycle N+60·`CLKS_PER_BIT`+1, with `UART_TXD`=1.
  - `done` is high for exactly one cycle.
- Start during the `done` cycle: it is accepted, since `busy`=0 then. The next message starts one cycle later.
- Input capture: `data` is registered at acceptance. Later changes on `data` do not affect the message in flight.

## Structure
- Shared package `uart_pkg`:
  - ASCII constants `ASCII_0`, `ASCII_A`, `ASCII_CR`, `ASCII_LF`.
  - FSM state enum (IDLE, START_BIT, DATA_BITS, STOP_BIT).
  - Default `CLKS_PER_BIT`.
- Sub-module `uart_byte_tx`:
  - Handles the baud counter, start/data/stop sequencing and the `UART_TXD` register.
  - Handshake: `load`/`byte_in`/`last_cycle`. `last_cycle` is high during the final stop-bit cycle, so the parent can load the next byte with zero gap.
- The parent `result_uart_tx` holds:
  - the data register;
  - the byte index;
  - the nibble-to-ASCII mux;
  - the `busy`/`done` logic.

## Test plan
All scenarios use `CLKS_PER_BIT`=4. The bench samples `UART_TXD` at bit centres.

- **Result 0x0009.** Pulse `start` with `data`=0x0009 (4+5 result) → bytes 0x30, 0x30, 0x30, 0x39, 0x0D, 0x0A. `done` pulses at cycle N+241, and `busy` is high for exactly 240 cycles.
- **All letters.** `data`=0xABCD → bytes 0x41, 0x42, 0x43, 0x44, 0x0D, 0x0A. Every stop bit is 1, and there is no idle gap between frames.
- **Start while busy.** `data`=0x1234 starts a message; pulse `start` with `data`=0xFFFF mid-message → the output is still "1234\r\n", followed by one `done` pulse and no second message.
- **Reset mid-frame.** Assert `rst`=0 during DATA_BITS of byte 2 → `UART_TXD`=1, `busy`=0, `done`=0 on the next edge. The line stays high after release until a new `start`.
- **Start in the done cycle.** Assert `start` with `data`=0x00FF in the `done` cycle → start bit at the next cycle, message "00FF\r\n".
- **Input change after acceptance.** Change `data` one cycle after acceptance → the transmitted digits match the value latched at acceptance.
